tx_packet_scheduler: RTL
========================

// Module: tx_packet_scheduler
// PURPOSE
//  Shares the single uart_tx byte transmitter between N_REQ packet sources
//  (trade reports, status/heartbeat, etc.). Each source gets a one-entry buffer.
//  A round-robin arbiter selects one full buffer at a time. The FSM then frames
//  that entry as a 5-byte packet (HEADER, type, data[15:8], data[7:0], FOOTER)
//  and drives the uart_tx enable/data handshake. Packets are never interleaved.
// PARAMETERS
//  N_REQ   2      number of requesters, 2..8
//  HEADER  8'hAA  first byte of every packet
//  FOOTER  8'h55  last byte of every packet
//  GW      -      derived localparam, max(1,$clog2(N_REQ)), not overridable
// PORTS
//  clk           in   1         system clock, 50 MHz
//  rst           in   1         synchronous reset, active-high
//  req_valid     in   N_REQ     bit i: source i presents a packet
//  req_type      in   8*N_REQ   slice [8i+:8]: type byte of source i
//  req_data      in   16*N_REQ  slice [16i+:16]: payload of source i
//  req_ready     out  N_REQ     bit i: buffer i is empty and can accept
//  uart_tx_busy  in   1         uart_tx is shifting a byte
//  uart_tx_en    out  1         one-cycle pulse: uart_tx takes uart_tx_data
//  uart_tx_data  out  8         byte for uart_tx
//  grant_id      out  GW        source index of the packet in flight
//  pkt_busy      out  1         FSM is not in IDLE
//  pkt_done      out  1         one-cycle pulse, same cycle as the FOOTER enable
// BEHAVIOUR
//  Reset values
//   - All buffers empty; req_ready = all 1s.
//   - uart_tx_en=0, uart_tx_data=0, grant_id=0, pkt_busy=0, pkt_done=0.
//   - FSM in IDLE; rr_ptr=0.
//  Accept
//   - req_ready[i] = !full[i], from a register.
//   - A source transfers on a clock edge where req_valid[i] & req_ready[i];
//     type and data are captured and full[i] is set.
//   - valid with ready=0 is a stall, not a drop; the source holds its inputs.
//  Arbitration
//   - Happens only in IDLE.
//   - Grant goes to the first full[i] found searching from rr_ptr upward,
//     with wrap-around.
//   - On grant: copy the buffer into the shadow registers, clear full[i],
//     set grant_id=i, set rr_ptr=(i+1) mod N_REQ, go to HDR.
//   - req_ready[i] returns to 1 the cycle after the grant. Result: one packet
//     can wait in the buffer while the previous one is transmitting.
//  FSM states: IDLE -> HDR -> TYP -> DHI -> DLO -> FTR -> IDLE
//   - Each non-IDLE state issues its byte and advances only when
//     issue = !uart_tx_busy && !uart_tx_en.
//   - The uart_tx_en term covers the one-cycle lag before uart_tx raises busy.
//   - On issue: uart_tx_en=1 for exactly one cycle, and uart_tx_data is set to
//     HEADER / type / data[15:8] / data[7:0] / FOOTER according to the state.
//   - uart_tx_data holds its value until the next issue. It is not zeroed.
//   - FTR issue pulses pkt_done and returns to IDLE.
//   - A new grant may occur in the cycle after FTR.
//  Latency
//   - Grant occurs 1 cycle after buffer load if the FSM is IDLE.
//   - HEADER enable occurs 1 cycle after grant if uart_tx is idle.
//   - With uart_tx idle, the minimum spacing between enables is 2 cycles.
//  Invariants
//   - uart_tx_en is never high on two consecutive cycles.
//   - uart_tx_en is never high while uart_tx_busy=1.
//   - Exactly 5 enables per packet.
//  Simultaneous events
//   - Accept on slot i in the same cycle slot i is granted cannot happen,
//     because ready=0 while full.
//   - Accepts on other slots proceed during grant and during transmission.
//  Reset mid-packet
//   - FSM returns to IDLE and buffers are cleared.
//   - No further bytes are issued; no FOOTER is sent.
//   - The next packet starts with HEADER.
// TESTING
//  1. Slot0 type=8'h01 data=16'h1234; uart model holds busy 10 cycles after each
//     enable -> bytes AA 01 12 34 55, grant_id=0, one pkt_done.
//  2. Slots 0 and 1 both valid in the same cycle after reset -> slot0 packet
//     then slot1 packet, not interleaved. Slot0 requests continuously with one
//     extra slot1 request -> grant order 0,1,0.
//  3. Slot0 sends 3 requests back-to-back -> 1st granted, 2nd buffered
//     (ready=1 the cycle after grant), 3rd stalls with ready=0 until the 2nd
//     is granted. 15 bytes total, in order.
//  4. uart_tx_busy forced high for 100 cycles in DHI -> no enable. Enable is
//     issued on the first cycle busy is low.
//  5. rst for 1 cycle right after the TYP enable -> uart_tx_en=0, req_ready all
//     1s, pkt_busy=0. The next request yields AA type dh dl 55.
//  6. Random traffic on 4 slots, 2000 packets -> scoreboard matches every
//     packet; en never high in consecutive cycles or while busy=1.

Source files
------------

// File: rtl/tx_packet_scheduler.sv
`timescale 1ns/1ps
// tx_packet_scheduler
//   Shares one uart_tx byte transmitter between N_REQ packet sources. Each
//   source owns a one-entry buffer; a round-robin arbiter picks one full
//   buffer while idle, and the FSM frames it as HEADER, type, data[15:8],
//   data[7:0], FOOTER, issuing one byte per uart_tx enable pulse.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-source packet present
//   req_type      : per-source type byte, slice [8i+:8]
//   req_data      : per-source payload, slice [16i+:16]
//   req_ready     : per-source buffer empty (registered)
//   uart_tx_busy  : transmitter shifting a byte
//   uart_tx_en    : one-cycle pulse, transmitter takes uart_tx_data
//   uart_tx_data  : byte for the transmitter, held between pulses
//   grant_id      : source index of the packet in flight
//   pkt_busy      : FSM not idle
//   pkt_done      : one-cycle pulse together with the FOOTER enable
module tx_packet_scheduler #(
  parameter int         N_REQ  = 2,
  parameter logic [7:0] HEADER = 8'hAA,
  parameter logic [7:0] FOOTER = 8'h55,
  localparam int        GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [8*N_REQ-1:0]  req_type,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                uart_tx_busy,
  output logic                uart_tx_en,
  output logic [7:0]          uart_tx_data,
  output logic [GW-1:0]       grant_id,
  output logic                pkt_busy,
  output logic                pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_TYP  = 3'd2,
    S_DHI  = 3'd3,
    S_DLO  = 3'd4,
    S_FTR  = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [N_REQ-1:0] full_r, full_nxt_s, ready_r, accept_s, clr_mask_s;
  logic [7:0]       type_buf_r [N_REQ];
  logic [15:0]      data_buf_r [N_REQ];
  logic [7:0]       sh_type_r;
  logic [15:0]      sh_data_r;
  logic [GW-1:0]    rr_ptr_r, rr_nxt_s, grant_r, grant_nxt_s, pick_s;
  logic [GW:0]      sum_s;
  logic             found_s, take_s, issue_s;
  logic             en_r, en_nxt_s, done_r, done_nxt_s, busy_r;
  logic [7:0]       data_r, data_nxt_s;

  assign accept_s = req_valid & ready_r;
  // The en term covers the cycle before uart_tx reports busy for the last byte.
  assign issue_s  = !uart_tx_busy && !en_r;

  // Round-robin search: first full slot at or above rr_ptr, with wrap-around.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    sum_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (GW+1)'(k);
      sum_s = (sum_s >= (GW+1)'(N_REQ)) ? (sum_s - (GW+1)'(N_REQ)) : sum_s;
      if (!found_s && full_r[sum_s[GW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = sum_s[GW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and byte issue logic for the framing FSM.
  always_comb begin
    state_nxt_s = state_r;
    en_nxt_s    = 1'b0;
    done_nxt_s  = 1'b0;
    data_nxt_s  = data_r;
    grant_nxt_s = grant_r;
    rr_nxt_s    = rr_ptr_r;
    take_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          take_s      = 1'b1;
          grant_nxt_s = pick_s;
          rr_nxt_s    = (pick_s == GW'(N_REQ-1)) ? '0 : (pick_s + GW'(1));
          state_nxt_s = S_HDR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (issue_s) begin
          en_nxt_s    = 1'b1;
          data_nxt_s  = HEADER;
          state_nxt_s = S_TYP;
        end else begin
          state_nxt_s = S_HDR;
        end
      end
      S_TYP: begin
        if (issue_s) begin
          en_nxt_s    = 1'b1;
          data_nxt_s  = sh_type_r;
          state_nxt_s = S_DHI;
        end else begin
          state_nxt_s = S_TYP;
        end
      end
      S_DHI: begin
        if (issue_s) begin
          en_nxt_s    = 1'b1;
          data_nxt_s  = sh_data_r[15:8];
          state_nxt_s = S_DLO;
        end else begin
          state_nxt_s = S_DHI;
        end
      end
      S_DLO: begin
        if (issue_s) begin
          en_nxt_s    = 1'b1;
          data_nxt_s  = sh_data_r[7:0];
          state_nxt_s = S_FTR;
        end else begin
          state_nxt_s = S_DLO;
        end
      end
      S_FTR: begin
        if (issue_s) begin
          en_nxt_s    = 1'b1;
          done_nxt_s  = 1'b1;
          data_nxt_s  = FOOTER;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_FTR;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Buffer occupancy: granted slot empties, accepted slots fill.
  always_comb begin
    clr_mask_s = take_s ? (N_REQ'(1) << pick_s) : '0;
    full_nxt_s = (full_r & ~clr_mask_s) | accept_s;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      full_r   <= '0;
      ready_r  <= '1;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      en_r     <= 1'b0;
      done_r   <= 1'b0;
      data_r   <= 8'h00;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      full_r   <= full_nxt_s;
      ready_r  <= ~full_nxt_s;
      rr_ptr_r <= rr_nxt_s;
      grant_r  <= grant_nxt_s;
      en_r     <= en_nxt_s;
      done_r   <= done_nxt_s;
      data_r   <= data_nxt_s;
      busy_r   <= (state_nxt_s != S_IDLE);
    end
  end

  // Payload storage; contents only matter while the matching full bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept_s[i]) begin
        type_buf_r[i] <= req_type[8*i +: 8];
        data_buf_r[i] <= req_data[16*i +: 16];
      end
    end
    if (take_s) begin
      sh_type_r <= type_buf_r[pick_s];
      sh_data_r <= data_buf_r[pick_s];
    end
  end

  assign req_ready    = ready_r;
  assign uart_tx_en   = en_r;
  assign uart_tx_data = data_r;
  assign grant_id     = grant_r;
  assign pkt_busy     = busy_r;
  assign pkt_done     = done_r;

endmodule
